// File: rtl/rr_stream_mux.sv
// rr_stream_mux
//   N-input, W-bit stream multiplexer with round-robin arbitration and a
//   single registered output stage. Every channel uses a valid/ready
//   handshake. Beats pass through with one cycle of latency. At out_ready=1
//   the block sustains one beat per cycle.
//
// Parameters
//   DATA_WIDTH  payload bits per channel
//   NUM_INPUTS  number of input channels (>= 2, any count)
//   SEL_WIDTH   channel index width, equal to clog2(NUM_INPUTS)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    channel payloads; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   per-channel beat valid
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel accept. This is combinational and depends on out_ready.
//   out_data   registered payload
//   out_last   registered last flag
//   out_sel    index of the channel that sourced the registered beat
//   out_valid  output register holds a beat
//   out_ready  consumer accept. It must not depend on in_ready.
//
// Configuration
//   MUX_ARB_LOCK_EN  When this is defined, a beat with in_last=0 locks
//                    arbitration to its channel until that channel sends a
//                    beat with in_last=1. When it is undefined, arbitration
//                    is per beat and in_last is only passed through.

module rr_stream_mux #(
    parameter int DATA_WIDTH = 3,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS-1:0]            in_last,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic [SEL_WIDTH-1:0]             out_sel,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam logic [SEL_WIDTH-1:0] PTR_RESET = SEL_WIDTH'(NUM_INPUTS - 1);

    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_last_q,  out_last_d;
    logic [SEL_WIDTH-1:0]  out_sel_q,   out_sel_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_WIDTH-1:0]  ptr_q,       ptr_d;
`ifdef MUX_ARB_LOCK_EN
    logic                  lock_q,      lock_d;
    logic [SEL_WIDTH-1:0]  lock_idx_q,  lock_idx_d;
`endif

    logic                  load_en;
    logic                  rr_found;
    logic [SEL_WIDTH-1:0]  rr_idx;
    logic                  grant_found;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [NUM_INPUTS-1:0] grant;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

    assign load_en = !out_valid_q || out_ready;

    // The round-robin scan runs in two passes. The first pass covers the
    // channels above the pointer. The second pass wraps to the channels at or
    // below it. This avoids modulo arithmetic, so NUM_INPUTS does not have to
    // be a power of two.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!rr_found && in_valid[i] && (SEL_WIDTH'(i) > ptr_q)) begin
                rr_found = 1'b1;
                rr_idx   = SEL_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!rr_found && in_valid[i] && (SEL_WIDTH'(i) <= ptr_q)) begin
                rr_found = 1'b1;
                rr_idx   = SEL_WIDTH'(i);
            end
        end
    end

    always_comb begin
        grant_found = rr_found;
        grant_idx   = rr_idx;
`ifdef MUX_ARB_LOCK_EN
        // While a packet is open, only its channel may win. If that channel
        // is idle, nobody wins.
        if (lock_q) begin
            grant_found = in_valid[lock_idx_q];
            grant_idx   = lock_idx_q;
        end
`endif
        grant = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            grant[i] = grant_found && (grant_idx == SEL_WIDTH'(i));
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last = in_last[i];
            end
        end
    end

    assign in_ready = load_en ? grant : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
`ifdef MUX_ARB_LOCK_EN
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
`endif
        if (load_en) begin
            // If the register is free or draining and no channel is valid, it
            // empties. The pointer only moves on a real transfer.
            out_valid_d = grant_found;
            if (grant_found) begin
                out_data_d = sel_data;
                out_last_d = sel_last;
                out_sel_d  = grant_idx;
                ptr_d      = grant_idx;
`ifdef MUX_ARB_LOCK_EN
                lock_d     = !sel_last;
                lock_idx_d = grant_idx;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= PTR_RESET;
`ifdef MUX_ARB_LOCK_EN
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
`ifdef MUX_ARB_LOCK_EN
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Testbench for rr_stream_mux. It combines directed scenarios with
// randomized traffic. Both are checked every cycle against a behavioural
// reference model.

module tb_rr_stream_mux;

    localparam int W = 3;
    localparam int N = 4;
    localparam int S = 2;
`ifdef MUX_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [S-1:0]   out_sel;
    logic           out_valid;
    logic           out_ready;

    rr_stream_mux #(.DATA_WIDTH(W), .NUM_INPUTS(N), .SEL_WIDTH(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state
    bit           m_valid;
    bit           m_last;
    bit           m_lock;
    int           m_data;
    int           m_sel;
    int           m_ptr;
    int           m_lock_idx;
    logic [N-1:0] last_hs;

    task automatic m_reset();
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = 0;
        m_sel      = 0;
        m_ptr      = N - 1;
        m_lock     = 1'b0;
        m_lock_idx = 0;
    endtask

    // Return the winning channel for the current inputs, or -1 if none.
    function automatic int pick();
        if (LOCK && m_lock) return in_valid[m_lock_idx] ? m_lock_idx : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Run one clock cycle. Inputs must already be driven. At the negedge the
    // task checks the DUT against the model, then advances the model, and it
    // returns 1 time unit after the posedge.
    task automatic tick();
        int           g;
        bit           load;
        logic [N-1:0] er;
        @(negedge clk);
        g    = pick();
        load = !m_valid || out_ready;
        er   = (load && g >= 0) ? (N'(1) << g) : '0;
        last_hs = in_valid & in_ready;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_data", 32'(out_data), m_data);
            chk("out_last", 32'(out_last), 32'(m_last));
            chk("out_sel", 32'(out_sel), m_sel);
        end
        if (rst) begin
            m_reset();
        end else if (load) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_data = 32'(in_data[g*W +: W]);
                m_last = in_last[g];
                m_sel  = g;
                m_ptr  = g;
                if (LOCK) begin
                    m_lock     = !in_last[g];
                    m_lock_idx = g;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    int sels[5];
    int sent;

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        m_reset();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_sel", 32'(out_sel), 0);
        chk("rst_last", 32'(out_last), 0);

        // 1: all channels valid, round robin starting at ch0
        rst       = 1'b0;
        in_valid  = '1;
        in_data   = {3'd4, 3'd3, 3'd2, 3'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_sel", 32'(out_sel), i % 4);
            chk("t1_data", 32'(out_data), (i % 4) + 1);
        end

        // 2: backpressure holds ch2 beat, then streaming from ch2
        in_valid = '0;
        tick();
        chk("t2_drain", 32'(out_valid), 0);
        in_valid  = 4'b0100;
        in_data   = {3'd0, 3'd5, 3'd0, 3'd0};
        out_ready = 1'b0;
        tick();
        chk("t2_sel", 32'(out_sel), 2);
        chk("t2_data", 32'(out_data), 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_valid", 32'(out_valid), 1);
            chk("t2_hold_data", 32'(out_data), 5);
            chk("t2_hold_sel", 32'(out_sel), 2);
            chk("t2_hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_accept", 32'(last_hs[2]), 1);
        end

        // 3: wrap from the top channel to ch0
        in_valid = 4'b1000;
        tick();
        chk("t3_sel3", 32'(out_sel), 3);
        in_valid = 4'b1001;
        tick();
        chk("t3_wrap", 32'(out_sel), 0);

        // 4: reset while under backpressure
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        tick();
        chk("t4_bp_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        chk("t4_rst_valid", 32'(out_valid), 0);
        chk("t4_rst_data", 32'(out_data), 0);
        chk("t4_rst_sel", 32'(out_sel), 0);
        rst       = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        tick();
        chk("t4_first", 32'(out_sel), 0);

        // 5: ch1 sends a 3-beat packet while ch0 and ch3 stay valid
        sent = 0;
        in_data = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            in_valid = {1'b1, 1'b0, (sent < 3), 1'b1};
            in_last  = {1'b1, 1'b1, (sent == 2), 1'b1};
            tick();
            if (last_hs[1]) sent++;
            sels[i] = 32'(out_sel);
        end
        if (LOCK) begin
            chk("t5_lock0", sels[0], 1);
            chk("t5_lock1", sels[1], 1);
            chk("t5_lock2", sels[2], 1);
            chk("t5_lock3", sels[3], 3);
            chk("t5_lock4", sels[4], 0);
        end else begin
            chk("t5_rr0", sels[0], 1);
            chk("t5_rr1", sels[1], 3);
            chk("t5_rr2", sels[2], 0);
            chk("t5_rr3", sels[3], 1);
        end

        // 6: idle after drain, then a lone ch3
        in_valid = '0;
        in_last  = '1;
        tick();
        tick();
        chk("t6_idle", 32'(out_valid), 0);
        in_valid = 4'b1000;
        tick();
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_sel", 32'(out_sel), 3);

        // Randomized traffic with occasional reset, checked by the model
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = N'($urandom);
            in_data   = (N*W)'($urandom);
            in_last   = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
